ehl_apb_master: RTL and testbench
=================================

Name: ehl_apb_master

Overview:
- Converts a generic valid/ready request/response interface into single AMBA APB3 transfers.
- Sits directly upstream of APB slaves such as the ROM/RAM APB wrappers; typically driven by a CPU fetch/load unit or a DMA engine.
- One outstanding transfer at a time.
- Adds misaligned-address rejection and a pready watchdog, so a hung slave cannot stall the requester forever.

Parameters:
- AWIDTH, 32, request/APB address width (bits).
- TIMEOUT, 256, max ACCESS-phase cycles with pready low before abort; 0 disables the watchdog.
- CHECK_ALIGN, 1, 1 rejects requests with req_addr[1:0] != 0.

Ports:
- pclk  input  1  clock
- presetn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  AWIDTH  byte address
- req_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  output  32  read data (0 for writes and errors)
- rsp_err  output  1  pslverr, misalignment or timeout
- rsp_tout  output  1  error cause was the watchdog
- paddr  output  AWIDTH  APB address
- pwrite  output  1  APB direction
- psel  output  1  APB select
- penable  output  1  APB enable
- pwdata  output  32  APB write data
- pready  input  1  slave ready
- pslverr  input  1  slave error
- prdata  input  32  slave read data

Behaviour:
- Reset (async, presetn low): state IDLE; psel, penable, rsp_valid, rsp_err, rsp_tout = 0; paddr, pwdata, pwrite, rsp_rdata = 0; watchdog counter = 0.
- Reset mid-transfer drops psel/penable immediately. No response is generated for the aborted request.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1; req_ready = 0 in all other states.
  - On acceptance, register addr/wdata/write into paddr/pwdata/pwrite.
  - If CHECK_ALIGN and addr[1:0] != 0: go to RESP with rsp_err = 1, no APB activity.
  - Otherwise go to SETUP.
- SETUP: psel = 1, penable = 0, for exactly one cycle; then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; paddr/pwrite/pwdata held stable.
  - On pready = 1: capture prdata (reads only; 0 for writes) and pslverr into rsp_rdata/rsp_err; go to RESP.
  - While pready = 0, the counter increments.
  - When the counter reaches TIMEOUT (TIMEOUT != 0) with pready still 0: drop psel/penable; go to RESP with rsp_err = 1, rsp_tout = 1, rsp_rdata = 0.
  - This abort is a deliberate protocol violation, accepted as fatal-error handling.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_err/rsp_tout held stable until rsp_ready.
  - On rsp_ready: go to IDLE, clear rsp_valid/rsp_err/rsp_tout, clear the counter.
- Latency, zero-wait slave: accept cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3, next accept cycle 4. Minimum 4 cycles per transfer.
- Outside SETUP/ACCESS: psel = 0 and penable = 0. paddr keeps its last value (no toggling when idle).
- Watchdog counter width is clog2(TIMEOUT+1) and saturates; pready = 1 on the same cycle the limit is reached wins, so the transfer completes normally.
- pslverr is sampled only when pready = 1. prdata is ignored for writes.

Decomposition:
- Shared package ehl_apb_pkg: FSM state encodings (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3) and an APB data-width constant of 32.
- Sub-module ehl_apb_watchdog: saturating counter with clear/enable/limit-reached output, reusable by future APB/AHB masters.
- Everything else is a single flat module.

Test Plan:
- Read 0x0000_0010, zero-wait slave returning prdata = 0xDEAD_BEEF -> psel high cycles 1–2, penable cycle 2; rsp_valid cycle 3 with rsp_rdata = 0xDEAD_BEEF, rsp_err = 0.
- Write 0x24 with data 0x1234_5678; slave holds pready low 3 cycles -> pwdata/paddr stable through all ACCESS cycles; response rsp_err = 0, rsp_rdata = 0.
- Read 0x13 with CHECK_ALIGN = 1 -> psel never asserted; rsp_valid next cycle with rsp_err = 1, rsp_tout = 0.
- TIMEOUT = 4, slave never ready -> psel/penable drop after 4 ACCESS cycles; rsp_err = 1, rsp_tout = 1, rsp_rdata = 0. Then a normal read succeeds.
- Slave returns pslverr = 1 with pready -> rsp_err = 1, rsp_tout = 0. Hold rsp_ready = 0 for 5 cycles -> outputs stable and req_ready = 0 throughout.
- Assert presetn low during ACCESS -> psel/penable/rsp_valid = 0 asynchronously. After release, req_ready = 1 and a new read completes in 4 cycles.

Source files
------------

// File: rtl/ehl_apb_pkg.sv
// ehl_apb_pkg
//   Shared definitions for the APB master slice: FSM state encoding, the APB
//   data width and a helper that sizes watchdog counters.
package ehl_apb_pkg;

  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Counter width able to hold 0..limit; a disabled (0) limit still gets one bit.
  function automatic int wd_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ehl_apb_master_if.sv
// ehl_apb_master_if
//   Bundles the requester-side valid/ready request/response channel and the
//   APB3 bus of ehl_apb_master.
//   master modport : the view of ehl_apb_master (drives req_ready, rsp_*, APB
//                    request signals; receives req_*, rsp_ready, pready,
//                    pslverr, prdata).
//   slave modport  : the opposite view, used by the environment around it.
interface ehl_apb_master_if #(
  parameter int AWIDTH = 32
);
  import ehl_apb_pkg::*;

  // request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AWIDTH-1:0] req_addr;
  logic [APB_DW-1:0] req_wdata;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [APB_DW-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tout;

  // APB3 bus
  logic [AWIDTH-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [APB_DW-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [APB_DW-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
           paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
           paddr, pwrite, psel, penable, pwdata
  );

endinterface

// File: rtl/ehl_apb_watchdog.sv
// ehl_apb_watchdog
//   Saturating event counter with a limit-reached flag, meant for bus-master
//   ready watchdogs.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count this cycle (e.g. slave not ready)
//   limit_hit  : this enabled cycle is the LIMIT-th counted one; never set
//                when LIMIT = 0 (watchdog disabled)
module ehl_apb_watchdog
  import ehl_apb_pkg::*;
#(
  parameter int LIMIT = 256,
  parameter int CW    = wd_width(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic limit_hit
);

  localparam logic [CW-1:0] LIM    = CW'(LIMIT);
  localparam logic [CW-1:0] LIM_M1 = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;
  localparam bit            ACTIVE = (LIMIT > 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIM)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flag the cycle whose increment brings the count to LIMIT, so the owner
  // can act on exactly the LIMIT-th stalled cycle.
  assign limit_hit = ACTIVE && en && (cnt >= LIM_M1);

endmodule

// File: rtl/ehl_apb_master.sv
// ehl_apb_master
//   Turns one valid/ready request into one APB3 transfer and returns a single
//   response. One transfer outstanding at a time; misaligned requests are
//   rejected without touching the bus, and a watchdog aborts transfers whose
//   slave keeps pready low for TIMEOUT ACCESS cycles.
//   pclk    : clock
//   presetn : asynchronous active-low reset
//   bus     : ehl_apb_master_if.master -- request channel (req_valid/ready,
//             req_write, req_addr, req_wdata), response channel (rsp_valid/
//             ready, rsp_rdata, rsp_err, rsp_tout) and APB3 bus (paddr,
//             pwrite, psel, penable, pwdata, pready, pslverr, prdata).
module ehl_apb_master
  import ehl_apb_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int TIMEOUT     = 256,
  parameter int CHECK_ALIGN = 1
) (
  input  logic             pclk,
  input  logic             presetn,
  ehl_apb_master_if.master bus
);

  localparam bit ALIGN_ON = (CHECK_ALIGN != 0);

  function automatic logic misaligned(input logic [1:0] lsb);
    return ALIGN_ON && (lsb != 2'b00);
  endfunction

  apb_state_e state;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_hit;

  // Counts stalled ACCESS cycles; cleared when the response is consumed.
  assign wd_en  = (state == ACCESS) && !bus.pready;
  assign wd_clr = (state == RESP) && bus.rsp_ready;

  ehl_apb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk       (pclk),
    .rst_n     (presetn),
    .clr       (wd_clr),
    .en        (wd_en),
    .limit_hit (wd_hit)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.paddr     <= '0;
      bus.pwrite    <= 1'b0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_tout  <= 1'b0;
    end else begin
      unique case (state)
        // accept a request and latch the transfer attributes
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            bus.paddr     <= bus.req_addr;
            bus.pwdata    <= bus.req_wdata;
            bus.pwrite    <= bus.req_write;
            if (misaligned(bus.req_addr[1:0])) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_tout  <= 1'b0;
              bus.rsp_rdata <= '0;
            end else begin
              state       <= SETUP;
              bus.psel    <= 1'b1;
              bus.penable <= 1'b0;
            end
          end
        end

        // single SETUP cycle
        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end

        // wait for the slave; pready in the limit cycle still completes
        ACCESS: begin
          if (bus.pready) begin
            state         <= RESP;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_tout  <= 1'b0;
            bus.rsp_rdata <= (bus.pwrite || bus.pslverr) ? '0 : bus.prdata;
          end else if (wd_hit) begin
            // Abandoning a live ACCESS breaks APB rules; this is the
            // last-resort escape from a hung slave.
            state         <= RESP;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_tout  <= 1'b1;
            bus.rsp_rdata <= '0;
          end
        end

        // hold the response until the requester takes it
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_tout  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ehl_apb_master.sv
module tb_ehl_apb_master;

  localparam int AW   = 32;
  localparam int TOUT = 4;

  logic pclk;
  logic presetn;

  ehl_apb_master_if #(.AWIDTH(AW)) bus ();

  ehl_apb_master #(
    .AWIDTH      (AW),
    .TIMEOUT     (TOUT),
    .CHECK_ALIGN (1)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- APB slave model ----------------
  int          cfg_wait  = 0;
  bit          cfg_err   = 0;
  logic [31:0] cfg_rdata = '0;
  int          acc_cnt;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else          acc_cnt <= (bus.psel && bus.penable) ? acc_cnt + 1 : 0;
  end

  assign bus.pready  = bus.psel && bus.penable && (acc_cnt == cfg_wait);
  assign bus.pslverr = bus.pready && cfg_err;
  // Read data is offered for writes too, so a DUT that forgets to zero it shows.
  assign bus.prdata  = (bus.pready && !cfg_err) ? cfg_rdata : 32'h0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          err;
    bit          tout;
    logic [31:0] rdata;
    int          n_setup;
    int          n_acc;
    int          lat;
  } exp_t;

  function automatic exp_t model(input bit wr, input logic [31:0] addr, input int waits,
                                 input bit serr, input logic [31:0] rdat);
    exp_t e;
    if (addr[1:0] != 2'b00) begin
      e.err = 1; e.tout = 0; e.rdata = 0; e.n_setup = 0; e.n_acc = 0; e.lat = 1;
      return e;
    end
    e.n_setup = 1;
    if (waits >= TOUT) begin
      e.n_acc = TOUT; e.err = 1; e.tout = 1; e.rdata = 0;
    end else begin
      e.n_acc = waits + 1; e.err = serr; e.tout = 0;
      e.rdata = (wr || serr) ? 32'h0 : rdat;
    end
    e.lat = 2 + e.n_acc;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends #1 after a rising edge.
  task automatic do_xfer(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits, input bit serr,
                         input logic [31:0] rdat, input int hold);
    exp_t e;
    int   n_setup, n_acc, lat;
    e = model(wr, addr, waits, serr, rdat);
    cfg_wait = waits; cfg_err = serr; cfg_rdata = rdat;

    for (int k = 0; k < 10 && !bus.req_ready; k++) begin
      @(posedge pclk); #1;
    end
    check({tag, ".req_ready"}, bus.req_ready, 1);

    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge pclk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;

    n_setup = 0; n_acc = 0; lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      if (bus.psel && !bus.penable) n_setup++;
      if (bus.psel && bus.penable) begin
        n_acc++;
        check({tag, ".paddr"}, bus.paddr, addr);
        check({tag, ".pwdata"}, bus.pwdata, wdata);
        check({tag, ".pwrite"}, bus.pwrite, wr);
      end
      @(posedge pclk); #1;
    end
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".setup_cycles"}, n_setup, e.n_setup);
    check({tag, ".access_cycles"}, n_acc, e.n_acc);
    check({tag, ".rsp_err"}, bus.rsp_err, e.err);
    check({tag, ".rsp_tout"}, bus.rsp_tout, e.tout);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, e.rdata);
    check({tag, ".psel_resp"}, {bus.psel, bus.penable}, 0);

    for (int h = 0; h < hold; h++) begin
      @(posedge pclk); #1;
      check({tag, ".hold_valid"}, bus.rsp_valid, 1);
      check({tag, ".hold_ready"}, bus.req_ready, 0);
      check({tag, ".hold_fields"}, {bus.rsp_err, bus.rsp_tout}, {e.err, e.tout});
      check({tag, ".hold_rdata"}, bus.rsp_rdata, e.rdata);
    end

    bus.rsp_ready = 1'b1;
    @(posedge pclk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, ".post_valid"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_tout}, 0);
    check({tag, ".post_req_ready"}, bus.req_ready, 1);
    check({tag, ".post_paddr"}, bus.paddr, addr);
  endtask

  bit          r_wr, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  int          r_waits, r_hold;

  initial begin
    presetn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    #12;
    check("reset.psel_penable", {bus.psel, bus.penable}, 0);
    check("reset.rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_tout}, 0);
    check("reset.paddr", bus.paddr, 0);
    check("reset.pwdata", bus.pwdata, 0);
    check("reset.pwrite", bus.pwrite, 0);
    check("reset.rsp_rdata", bus.rsp_rdata, 0);
    check("reset.req_ready", bus.req_ready, 1);
    #10 presetn = 1'b1;
    @(posedge pclk); #1;

    do_xfer("rd_zero_wait", 0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    do_xfer("wr_wait3", 1, 32'h0000_0024, 32'h1234_5678, 3, 0, 32'hCAFE_F00D, 0);
    do_xfer("rd_misaligned", 0, 32'h0000_0013, 32'h0, 0, 0, 32'h1111_2222, 0);
    do_xfer("rd_timeout", 0, 32'h0000_0040, 32'h0, 1000, 0, 32'h3333_4444, 0);
    do_xfer("rd_after_tout", 0, 32'h0000_0044, 32'h0, 1, 0, 32'h5555_6666, 0);
    do_xfer("wr_tout_edge", 1, 32'h0000_0060, 32'hA5A5_5A5A, TOUT, 0, 32'h0, 1);
    do_xfer("rd_slverr", 0, 32'h0000_0050, 32'h0, 0, 1, 32'h7777_8888, 5);

    // reset while the slave stalls in ACCESS
    cfg_wait = 1000; cfg_err = 0; cfg_rdata = 32'h9999_AAAA;
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    bus.req_addr = 32'h0000_0080; bus.req_wdata = 32'h0;
    @(posedge pclk); #1;
    bus.req_valid = 1'b0;
    @(posedge pclk); #1;
    check("rst_mid.in_access", {bus.psel, bus.penable}, 2'b11);
    #3 presetn = 1'b0;
    #1;
    check("rst_mid.psel_penable", {bus.psel, bus.penable}, 0);
    check("rst_mid.rsp_valid", bus.rsp_valid, 0);
    #2 presetn = 1'b1;
    @(posedge pclk); #1;
    check("rst_mid.req_ready", bus.req_ready, 1);
    check("rst_mid.no_rsp", bus.rsp_valid, 0);
    do_xfer("rd_after_rst", 0, 32'h0000_0084, 32'h0, 0, 0, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 24; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = $urandom & 32'h0000_FFFC;
      if ($urandom_range(0, 4) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_waits = $urandom_range(0, 6);
      r_err   = ($urandom_range(0, 4) == 0);
      r_hold  = $urandom_range(0, 2);
      do_xfer($sformatf("rnd%0d", i), r_wr, r_addr, r_wdata, r_waits, r_err, r_rdata, r_hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
